// File: rtl/ddr_definitions.sv
// Shared constants, FSM encodings and arrow helpers for the arrow judge.
package ddr_definitions;

    localparam int ARROW_BASE = 10;
    localparam int NUM_ARROWS = 5;
    localparam int ARROW_W    = 4;
    localparam int SCORE_W    = 16;
    localparam int COMBO_W    = 8;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } judge_state_e;

    function automatic logic arrow_legal(input logic [ARROW_W-1:0] code);
        return (code >= ARROW_W'(ARROW_BASE)) &&
               (code < ARROW_W'(ARROW_BASE + NUM_ARROWS));
    endfunction

    function automatic logic [NUM_ARROWS-1:0] arrow_onehot(
        input logic [ARROW_W-1:0] code
    );
        logic [ARROW_W-1:0] idx;
        idx = code - ARROW_W'(ARROW_BASE);
        return NUM_ARROWS'(1) << idx;
    endfunction

endpackage

// File: rtl/arrow_fifo.sv
// Arrow queue: power-of-two circular buffer with occupancy count.
module arrow_fifo
    import ddr_definitions::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ARROW_W-1:0]       din,
    output logic [ARROW_W-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [ARROW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      rptr_q, wptr_q;
    logic [PW:0]        count_q, count_d;
    logic               do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/arrow_judge.sv
// Rhythm-game judge: queues arrows and scores timed button presses.
// Optional build macro ARROW_JUDGE_COMBO_BONUS_EN adds combo[7:3] per hit.
module arrow_judge
    import ddr_definitions::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned WINDOW     = 1000,
    parameter int unsigned HIT_POINTS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ARROW_W-1:0]    arrow_in,
    input  logic                  arrow_valid,
    input  logic                  play,
    input  logic [NUM_ARROWS-1:0] btn,
    output logic [ARROW_W-1:0]    head_arrow,
    output logic                  head_valid,
    output logic                  hit,
    output logic                  miss,
    output logic [SCORE_W-1:0]    score,
    output logic [COMBO_W-1:0]    combo,
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [15:0] WIN_LOAD = 16'(WINDOW - 1);
    localparam logic [SCORE_W-1:0] HIT_ADD = SCORE_W'(HIT_POINTS);

    judge_state_e state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0]  score_q, score_d, hit_add;
    logic [SCORE_W:0]    score_sum;
    logic [COMBO_W-1:0]  combo_q, combo_d;
    logic                hit_q, miss_q, ovf_q, ovf_d;
    logic                judge_hit, judge_miss, pop;
    logic                push_req;
    logic [ARROW_W-1:0]  fifo_dout;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic                queued;

    assign push_req = arrow_valid & arrow_legal(arrow_in);
    assign queued   = (fifo_count != '0);

    arrow_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (arrow_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (queued) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = WIN_LOAD;
                end
            end
            ST_ACTIVE: begin
                // A press on the last window cycle beats the timeout.
                if (play) begin
                    if (btn != '0) begin
                        pop     = 1'b1;
                        state_d = ST_GAP;
                        if (btn == arrow_onehot(fifo_dout)) judge_hit = 1'b1;
                        else judge_miss = 1'b1;
                    end else if (cnt_q == '0) begin
                        pop        = 1'b1;
                        judge_miss = 1'b1;
                        state_d    = ST_GAP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (queued) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = WIN_LOAD;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

`ifdef ARROW_JUDGE_COMBO_BONUS_EN
    assign hit_add = HIT_ADD + SCORE_W'(combo_q[COMBO_W-1:3]);
`else
    assign hit_add = HIT_ADD;
`endif

    assign score_sum = {1'b0, score_q} + {1'b0, hit_add};

    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        if (judge_hit) begin
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (combo_q != '1) combo_d = combo_q + 1'b1;
        end else if (judge_miss) begin
            combo_d = '0;
        end
    end

    assign ovf_d = ovf_q | (push_req & fifo_full & ~pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            combo_q <= combo_d;
            hit_q   <= judge_hit;
            miss_q  <= judge_miss;
            ovf_q   <= ovf_d;
        end
    end

    assign head_valid = ~fifo_empty;
    assign head_arrow = fifo_empty ? '0 : fifo_dout;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_arrow_judge.sv
// Directed self-checking bench for arrow_judge (DEPTH=4, WINDOW=8).
module tb_arrow_judge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] arrow_in;
    logic       arrow_valid;
    logic       play;
    logic [4:0] btn;
    logic [3:0] head_arrow;
    logic       head_valid;
    logic       hit;
    logic       miss;
    logic [15:0] score;
    logic [7:0] combo;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int exp_score;
    int exp_combo;

`ifdef ARROW_JUDGE_COMBO_BONUS_EN
    localparam int ADD_AT_16 = 12;
`else
    localparam int ADD_AT_16 = 10;
`endif

    arrow_judge #(
        .DEPTH(4),
        .WINDOW(8),
        .HIT_POINTS(10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arrow_in    (arrow_in),
        .arrow_valid (arrow_valid),
        .play        (play),
        .btn         (btn),
        .head_arrow  (head_arrow),
        .head_valid  (head_valid),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .combo       (combo),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        arrow_in    = '0;
        arrow_valid = 1'b0;
        play        = 1'b1;
        btn         = '0;
        exp_score   = 0;
        exp_combo   = 0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [3:0] code);
        arrow_in    = code;
        arrow_valid = 1'b1;
        step();
        arrow_valid = 1'b0;
        arrow_in    = '0;
    endtask

    task automatic model_hit();
        int add;
        add = 10;
`ifdef ARROW_JUDGE_COMBO_BONUS_EN
        add += exp_combo >> 3;
`endif
        exp_score = exp_score + add;
        if (exp_score > 65535) exp_score = 65535;
        if (exp_combo < 255) exp_combo++;
    endtask

    function automatic logic [4:0] oh(input logic [3:0] code);
        logic [4:0] one;
        one = 5'd1;
        return one << (code - 4'd10);
    endfunction

    initial begin
        logic seen;
        int prev;
        int pc;
        int sat;
        logic [3:0] code;

        do_reset();
        chk("rst_head", head_arrow, 0);
        chk("rst_hv", head_valid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_ovf", overflow, 0);

        // hit on window cycle 3
        push(4'd12);
        chk("h1_head", head_arrow, 12);
        chk("h1_hv", head_valid, 1);
        step();
        step();
        step();
        btn = 5'b00100;
        step();
        btn = '0;
        model_hit();
        chk("h1_hit", hit, 1);
        chk("h1_miss", miss, 0);
        chk("h1_score", score, 10);
        chk("h1_combo", combo, 1);
        chk("h1_hv0", head_valid, 0);
        step();
        chk("h1_pulse", hit, 0);

        // timeout miss
        push(4'd10);
        step();
        seen = 1'b0;
        repeat (7) begin
            step();
            seen |= miss | hit;
        end
        chk("to_early", seen, 0);
        step();
        exp_combo = 0;
        chk("to_miss", miss, 1);
        chk("to_score", score, 10);
        chk("to_combo", combo, 0);
        step();

        // wrong button, then hit on last window cycle
        push(4'd11);
        step();
        btn = 5'b00001;
        step();
        btn = '0;
        chk("wb_miss", miss, 1);
        chk("wb_hit", hit, 0);
        step();
        push(4'd11);
        step();
        seen = 1'b0;
        repeat (7) begin
            step();
            seen |= miss;
        end
        chk("lw_early", seen, 0);
        btn = 5'b00010;
        step();
        btn = '0;
        model_hit();
        chk("lw_hit", hit, 1);
        chk("lw_miss", miss, 0);
        chk("lw_score", score, 20);
        chk("lw_combo", combo, 1);
        step();

        // play=0 freezes the window and ignores buttons
        push(4'd13);
        step();
        play = 1'b0;
        btn  = 5'b01000;
        seen = 1'b0;
        repeat (20) begin
            step();
            seen |= hit | miss;
        end
        chk("frz_pulse", seen, 0);
        chk("frz_hv", head_valid, 1);
        btn  = '0;
        play = 1'b1;
        step();
        step();
        btn = 5'b01000;
        step();
        btn = '0;
        model_hit();
        chk("frz_hit", hit, 1);
        chk("frz_score", score, 30);
        chk("frz_combo", combo, 2);
        step();

        // overflow behaviour
        do_reset();
        push(4'd10);
        push(4'd11);
        push(4'd12);
        push(4'd13);
        chk("of_cnt4", dut.u_fifo.count_q, 4);
        chk("of_ovf0", overflow, 0);
        arrow_in    = 4'd14;
        arrow_valid = 1'b1;
        btn         = 5'b00001;
        step();
        arrow_valid = 1'b0;
        btn         = '0;
        chk("of_pp_hit", hit, 1);
        chk("of_pp_cnt", dut.u_fifo.count_q, 4);
        chk("of_pp_ovf", overflow, 0);
        chk("of_pp_head", head_arrow, 11);
        push(4'd14);
        chk("of_ovf1", overflow, 1);
        chk("of_cnt", dut.u_fifo.count_q, 4);
        chk("of_head", head_arrow, 11);

        // async reset mid-window with 3 queued
        btn = 5'b00010;
        step();
        btn = '0;
        step();
        step();
        chk("ar_cnt3", dut.u_fifo.count_q, 3);
        rst_n = 1'b0;
        #2;
        chk("ar_head", head_arrow, 0);
        chk("ar_hv", head_valid, 0);
        chk("ar_hit", hit, 0);
        chk("ar_miss", miss, 0);
        chk("ar_score", score, 0);
        chk("ar_combo", combo, 0);
        chk("ar_ovf", overflow, 0);
        step();
        rst_n = 1'b1;
        exp_score = 0;
        exp_combo = 0;
        step();
        push(4'd7);
        chk("ill7_hv", head_valid, 0);
        push(4'd15);
        push(4'd0);
        chk("ill_hv", head_valid, 0);
        chk("ill_head", head_arrow, 0);

        // long hit streak: combo and score saturation
        sat = 0;
        for (int i = 0; i < 7000; i++) begin
            code = 4'(10 + (i % 5));
            push(code);
            step();
            prev = exp_score;
            pc   = exp_combo;
            btn  = oh(code);
            step();
            btn = '0;
            model_hit();
            chk("st_hit", hit, 1);
            chk("st_score", score, exp_score);
            chk("st_combo", combo, exp_combo);
            if (pc == 16) chk("st_add16", score - prev, ADD_AT_16);
            if (i == 256) chk("st_c255", combo, 255);
            step();
            if (exp_score == 65535 && i > 260) sat++;
            if (sat == 3) break;
        end
        chk("sat_done", sat, 3);
        chk("sat_score", score, 16'hFFFF);
        chk("sat_combo", combo, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arrow_judge.md
ARROW_JUDGE -- requirements
Module: arrow_judge

Interface
REQ-001 Parameter DEPTH, default 4: arrow queue entries; power of two, 2..16.
REQ-002 Parameter WINDOW, default 1000: clk cycles the player has to answer the head arrow; 2..65535.
REQ-003 Parameter HIT_POINTS, default 10: base score added per hit.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port arrow_in  input  4: arrow code from the random arrow generator; legal codes 10..14.
REQ-007 Port arrow_valid  input  1: one-cycle push strobe for arrow_in, normally the metronome beat.
REQ-008 Port play  input  1: high = game running; low = window frozen and buttons ignored.
REQ-009 Port btn  input  5: one-cycle debounced press pulses; bit k answers arrow code 10+k.
REQ-010 Port head_arrow  output  4: code at queue head; 0 when the queue is empty.
REQ-011 Port head_valid  output  1: queue non-empty.
REQ-012 Port hit  output  1: one-cycle pulse per correct judgement.
REQ-013 Port miss  output  1: one-cycle pulse per wrong or late judgement.
REQ-014 Port score  output  16: accumulated score, saturating.
REQ-015 Port combo  output  8: consecutive hits, saturating.
REQ-016 Port overflow  output  1: sticky flag; an arrow was dropped because the queue was full.

Function
REQ-017 Push when arrow_valid=1 and arrow_in is 10..14; illegal codes SHALL be silently discarded.
REQ-018 Push when full SHALL be dropped and set overflow, unless a pop occurs in the same cycle; push and pop in one cycle SHALL both take effect.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; the occupancy count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-020 FSM states: EMPTY, ACTIVE, GAP.
REQ-021 EMPTY: when head_valid becomes 1, go to ACTIVE and load the window counter with WINDOW-1.
REQ-022 ACTIVE with play=1: the counter decrements each cycle. The head is judged as follows.
  - btn equal to onehot(head_arrow-10): hit.
  - Any other nonzero btn: miss.
  - Counter at 0 with btn=0: miss.
REQ-023 A press in the cycle where the counter is 0 SHALL be judged as a press, not a timeout.
REQ-024 ACTIVE with play=0: the counter holds and btn is ignored.
REQ-025 On judgement, the head SHALL pop in the same cycle. hit or miss SHALL pulse on the next cycle. The FSM SHALL enter GAP.
REQ-026 GAP SHALL last exactly 1 cycle with btn ignored. It then goes to ACTIVE with the counter reloaded if the queue is non-empty, else to EMPTY.
REQ-027 A hit SHALL add HIT_POINTS to score (saturating at 16'hFFFF) and increment combo (saturating at 255).
REQ-028 A miss SHALL clear combo to 0 and leave score unchanged.
REQ-029 score, combo and the hit/miss pulses SHALL update in the same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously clear the state as follows, at any time including mid-window.
  - FSM to EMPTY, pointers and count to 0.
  - score, combo, hit, miss and overflow to 0.
  - head_arrow to 0 and head_valid to 0.
REQ-031 Queue storage contents need not be reset.

Configuration
REQ-032 Macro ARROW_JUDGE_COMBO_BONUS_EN: when defined, a hit SHALL add HIT_POINTS + combo[7:3], where combo is the value before the increment. When undefined, a hit SHALL add exactly HIT_POINTS.

Structure
REQ-033 These constants SHALL live in the shared ddr_definitions include and SHALL NOT be redefined locally.
  - ARROW_BASE=10 and NUM_ARROWS=5.
  - Score width 16 and combo width 8.
  - The FSM state encodings.
REQ-034 The queue SHALL be a sub-module arrow_fifo with parameter DEPTH. Its ports: push, pop, din, dout, full, empty, count. It SHALL have no judging logic.

Verification
REQ-035 Push 12, WINDOW=8; btn=5'b00100 on window cycle 3 -> hit pulse, score=10, combo=1, EMPTY after GAP.
REQ-036 Push 10; no btn for 8 cycles -> miss on cycle 9, score unchanged, combo=0.
REQ-037 Push 11; btn=5'b00001 -> miss. Push 11 again; btn=5'b00010 in the final window cycle -> hit.
REQ-038 DEPTH=4: push 5 arrows with no pops -> overflow=1, count=4. With the queue full, push while a hit pops -> count stays 4 and overflow does not newly set.
REQ-039 Drive 255+2 consecutive hits -> combo=255 saturates. Force score near max -> score=16'hFFFF with no wrap. Bonus-enabled build: hit at combo=16 adds 12.
REQ-040 Assert rst_n low mid-window with 3 arrows queued -> all outputs 0 immediately, without waiting for a clock edge. Push 7 -> discarded, head_valid stays 0.
